// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter in front of one sram-like memory port: one transaction in flight,
// data side has priority, and a waiting instruction fetch is forced through after STARVE_MAX data grants.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t              state, state_nxt;
  logic                owner;
  logic                lat_wr;
  logic [1:0]          lat_size;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [3:0]          starve_cnt;

  logic                force_inst, grant_data, grant_inst, done;

  // Grants only exist in IDLE and never while rst is held, so outputs stay quiet during reset.
  always_comb begin
    force_inst = inst_req && (starve_cnt == STARVE_LIM);
    grant_data = 1'b0;
    grant_inst = 1'b0;
    if (!rst && state == IDLE) begin
      grant_data = data_req && !force_inst;
      grant_inst = inst_req && !grant_data;
    end
    done = !rst && (state == WAIT) && mem_data_ok;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_data || grant_inst) state_nxt = REQ;
      REQ:     if (mem_addr_ok) state_nxt = WAIT;
      WAIT:    if (mem_data_ok) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    inst_addr_ok = grant_inst;
    data_addr_ok = grant_data;
    inst_data_ok = done && !owner;
    data_data_ok = done && owner;
    inst_rdata   = '0;
    data_rdata   = '0;
    if (inst_data_ok) inst_rdata = mem_rdata;
    if (data_data_ok) data_rdata = mem_rdata;
    mem_req   = 1'b0;
    mem_wr    = 1'b0;
    mem_size  = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!rst && state == REQ) begin
      mem_req   = 1'b1;
      mem_wr    = lat_wr;
      mem_size  = lat_size;
      mem_addr  = lat_addr;
      mem_wdata = lat_wdata;
    end
    busy = !rst && (state != IDLE);
  end

  // Grant edge: capture the winner's request so the downstream side sees stable fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      lat_wr     <= 1'b0;
      lat_size   <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      starve_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (grant_data || grant_inst) begin
        owner     <= grant_data;
        lat_wr    <= grant_data ? data_wr    : inst_wr;
        lat_size  <= grant_data ? data_size  : inst_size;
        lat_addr  <= grant_data ? data_addr  : inst_addr;
        lat_wdata <= grant_data ? data_wdata : inst_wdata;
        if (grant_data && inst_req)
          starve_cnt <= (starve_cnt == STARVE_LIM) ? starve_cnt : starve_cnt + 4'd1;
        else
          starve_cnt <= '0;
      end
    end
  end

endmodule
